// File: rtl/dff_mem_pkg.sv
// rtl/dff_mem_pkg.sv - shared constants for the two-requester DFF RAM arbiter
package dff_mem_pkg;

    localparam int ADDR_W_DEF    = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int RAM_BYTES_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ISSUE   = 2'd1;
    localparam state_t CAPTURE = 2'd2;
    localparam state_t RESP    = 2'd3;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/dff_mem_arbiter_if.sv
// rtl/dff_mem_arbiter_if.sv - per-requester command/response bundle
interface dff_mem_arbiter_if
    import dff_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; priority flips only on an accepted grant
module rr_arb2
    import dff_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == REQ_B) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // grant[1] doubles as the requester id of the winner (REQ_B = 1)
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= REQ_B;
        else if (accept && (grant != 2'b00))
            last_grant <= grant[1];
    end
endmodule

// File: rtl/dff_mem_arbiter.sv
// rtl/dff_mem_arbiter.sv - serialises requesters A and B onto one single-port DFF RAM
module dff_mem_arbiter
    import dff_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RAM_BYTES = RAM_BYTES_DEF
)(
    input  logic                clk,
    input  logic                rst,
    dff_mem_arbiter_if.slave    a,
    dff_mem_arbiter_if.slave    b,
    output logic                mem_wr_en,
    output logic                mem_r_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_BYTES);

    state_t            state;
    logic              idle;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              accept;

    logic              sel_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    logic              owner;
    logic              cmd_rd;
    logic              cmd_err;
    logic [1:0]        resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;

    assign idle   = (state == IDLE);
    assign req    = {b.valid, a.valid} & {2{idle}};
    assign accept = idle & (grant != 2'b00);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    assign a.ready = grant[0];
    assign b.ready = grant[1];

    assign sel_b        = grant[1];
    assign sel_we       = sel_b ? b.we    : a.we;
    assign sel_addr     = sel_b ? b.addr  : a.addr;
    assign sel_wdata    = sel_b ? b.wdata : a.wdata;
    assign sel_in_range = ({1'b0, sel_addr} < RAM_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= REQ_A;
            cmd_rd       <= 1'b0;
            cmd_err      <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_r_en     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Out-of-range commands never touch the RAM but keep the same timing
                        owner     <= sel_b;
                        cmd_rd    <= ~sel_we & sel_in_range;
                        cmd_err   <= ~sel_in_range;
                        mem_wr_en <= sel_we & sel_in_range;
                        mem_r_en  <= ~sel_we & sel_in_range;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_wr_en <= 1'b0;
                    mem_r_en  <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    resp_valid_q <= (owner == REQ_B) ? 2'b10 : 2'b01;
                    resp_err_q   <= cmd_err;
                    resp_rdata_q <= cmd_rd ? mem_rdata : '0;
                    state        <= RESP;
                end
                default: begin
                    resp_valid_q <= 2'b00;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign a.resp_valid = resp_valid_q[REQ_A];
    assign a.resp_err   = resp_valid_q[REQ_A] & resp_err_q;
    assign a.resp_rdata = resp_valid_q[REQ_A] ? resp_rdata_q : '0;
    assign b.resp_valid = resp_valid_q[REQ_B];
    assign b.resp_err   = resp_valid_q[REQ_B] & resp_err_q;
    assign b.resp_rdata = resp_valid_q[REQ_B] ? resp_rdata_q : '0;
endmodule

// File: tb/tb_dff_mem_arbiter.sv
// tb/tb_dff_mem_arbiter.sv - self-checking bench for dff_mem_arbiter with a 16-byte RAM model
module tb_dff_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       mem_wr_en;
    logic       mem_r_en;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] ram     [16];
    logic [7:0] exp_mem [16];

    typedef struct {
        bit         owner;
        bit         err;
        logic [7:0] rdata;
        int         due;
    } exp_t;

    dff_mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) a_if ();
    dff_mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) b_if ();

    dff_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RAM_BYTES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a_if),
        .b         (b_if),
        .mem_wr_en (mem_wr_en),
        .mem_r_en  (mem_r_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behaviour of the DFF RAM macro: synchronous write, registered read
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr[3:0]] <= mem_wdata;
        if (mem_r_en)  mem_rdata <= ram[mem_addr[3:0]];
    end

    task automatic drive(input bit owner, input bit v, input bit we,
                         input logic [4:0] addr, input logic [7:0] wd);
        if (owner) begin
            b_if.valid = v; b_if.we = we; b_if.addr = addr; b_if.wdata = wd;
        end else begin
            a_if.valid = v; a_if.we = we; a_if.addr = addr; a_if.wdata = wd;
        end
    endtask

    task automatic xact(input bit owner, input bit we, input logic [4:0] addr, input logic [7:0] wd,
                        output int lat, output logic m_wr, output logic m_rd,
                        output logic [4:0] m_addr, output logic [7:0] m_wd,
                        output logic r_err, output logic [7:0] r_data,
                        output logic other_rv, output logic after_rv);
        bit acc;
        int w;
        lat = -1; m_wr = 1'bx; m_rd = 1'bx; m_addr = 'x; m_wd = 'x;
        r_err = 1'bx; r_data = 'x; other_rv = 1'bx; after_rv = 1'bx;
        drive(owner, 1'b1, we, addr, wd);
        acc = 1'b0;
        w = 0;
        while (!acc && w < 20) begin
            #1;
            acc = owner ? b_if.ready : a_if.ready;
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        drive(owner, 1'b0, 1'b0, 5'd0, 8'd0);
        if (!acc) return;
        m_wr = mem_wr_en; m_rd = mem_r_en; m_addr = mem_addr; m_wd = mem_wdata;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            if (owner ? b_if.resp_valid : a_if.resp_valid) begin
                lat      = k;
                r_err    = owner ? b_if.resp_err   : a_if.resp_err;
                r_data   = owner ? b_if.resp_rdata : a_if.resp_rdata;
                other_rv = owner ? a_if.resp_valid : b_if.resp_valid;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            after_rv = owner ? b_if.resp_valid : a_if.resp_valid;
        end
    endtask

    task automatic test_reset();
        logic [41:0] outs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        outs = {mem_wr_en, mem_r_en, mem_addr, mem_wdata,
                a_if.ready, a_if.resp_valid, a_if.resp_err, a_if.resp_rdata,
                b_if.ready, b_if.resp_valid, b_if.resp_err, b_if.resp_rdata};
        checks++;
        if (outs !== 42'd0) begin
            errors++; $display("FAIL reset_outputs got=%h expected=0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        bit   acc_a, acc_b;
        bit   own_q[$];
        int   cyc_q[$];
        bit   exp_owner[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        drive(1'b0, 1'b1, 1'b1, 5'd8, 8'h11);
        drive(1'b1, 1'b1, 1'b1, 5'd9, 8'h22);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (a_if.resp_valid !== (k % 8 == 3) || b_if.resp_valid !== (k % 8 == 7)) begin
                errors++;
                $display("FAIL tie_resp cycle=%0d got a=%b b=%b expected a=%b b=%b",
                         k, a_if.resp_valid, b_if.resp_valid, (k % 8 == 3), (k % 8 == 7));
            end
            #1;
            acc_a = a_if.valid & a_if.ready;
            acc_b = b_if.valid & b_if.ready;
            if (acc_a) begin own_q.push_back(1'b0); cyc_q.push_back(k); end
            if (acc_b) begin own_q.push_back(1'b1); cyc_q.push_back(k); end
            @(posedge clk);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        checks++;
        if (own_q.size() != 4) begin
            errors++; $display("FAIL tie_count got=%0d expected=4", own_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (own_q[i] !== exp_owner[i] || cyc_q[i] != 4 * i) begin
                    errors++;
                    $display("FAIL tie_order idx=%0d got owner=%0d cycle=%0d expected owner=%0d cycle=%0d",
                             i, own_q[i], cyc_q[i], exp_owner[i], 4 * i);
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic preload();
        int lat; logic wr, rd, e, orv, arv; logic [4:0] ma; logic [7:0] mw, rdat, d;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            xact(i[0], 1'b1, 5'(i), d, lat, wr, rd, ma, mw, e, rdat, orv, arv);
            exp_mem[i] = d;
            checks++;
            if (lat != 3 || wr !== 1'b1 || ma !== 5'(i) || mw !== d || e !== 1'b0 || rdat !== 8'd0) begin
                errors++;
                $display("FAIL preload addr=%0d got lat=%0d wr=%b addr=%0d wd=%h err=%b rdata=%h expected lat=3 wr=1 addr=%0d wd=%h err=0 rdata=0",
                         i, lat, wr, ma, mw, e, rdat, i, d);
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic wr, rd, e, orv, arv; logic [4:0] ma; logic [7:0] mw, rdat;
        xact(1'b0, 1'b1, 5'd5, 8'h3C, lat, wr, rd, ma, mw, e, rdat, orv, arv);
        exp_mem[5] = 8'h3C;
        checks++;
        if (wr !== 1'b1 || rd !== 1'b0 || ma !== 5'd5 || mw !== 8'h3C) begin
            errors++; $display("FAIL wr_mem_cmd got wr=%b rd=%b addr=%0d wd=%h expected wr=1 rd=0 addr=5 wd=3c", wr, rd, ma, mw);
        end
        checks++;
        if (lat != 3 || e !== 1'b0 || rdat !== 8'd0 || orv !== 1'b0 || arv !== 1'b0) begin
            errors++; $display("FAIL wr_resp got lat=%0d err=%b rdata=%h other=%b after=%b expected 3 0 00 0 0", lat, e, rdat, orv, arv);
        end
        xact(1'b0, 1'b0, 5'd5, 8'h00, lat, wr, rd, ma, mw, e, rdat, orv, arv);
        checks++;
        if (wr !== 1'b0 || rd !== 1'b1 || ma !== 5'd5) begin
            errors++; $display("FAIL rd_mem_cmd got wr=%b rd=%b addr=%0d expected wr=0 rd=1 addr=5", wr, rd, ma);
        end
        checks++;
        if (lat != 3 || e !== 1'b0 || rdat !== 8'h3C || arv !== 1'b0) begin
            errors++; $display("FAIL rd_resp got lat=%0d err=%b rdata=%h after=%b expected 3 0 3c 0", lat, e, rdat, arv);
        end
    endtask

    task automatic test_range();
        int lat; logic wr, rd, e, orv, arv; logic [4:0] ma; logic [7:0] mw, rdat;
        xact(1'b1, 1'b0, 5'd15, 8'h00, lat, wr, rd, ma, mw, e, rdat, orv, arv);
        checks++;
        if (lat != 3 || rd !== 1'b1 || e !== 1'b0 || rdat !== exp_mem[15]) begin
            errors++; $display("FAIL range_top got lat=%0d rd=%b err=%b rdata=%h expected 3 1 0 %h", lat, rd, e, rdat, exp_mem[15]);
        end
        xact(1'b1, 1'b0, 5'd20, 8'h00, lat, wr, rd, ma, mw, e, rdat, orv, arv);
        checks++;
        if (lat != 3 || wr !== 1'b0 || rd !== 1'b0 || e !== 1'b1 || rdat !== 8'd0) begin
            errors++; $display("FAIL range_20 got lat=%0d wr=%b rd=%b err=%b rdata=%h expected 3 0 0 1 00", lat, wr, rd, e, rdat);
        end
        xact(1'b0, 1'b1, 5'd16, 8'hEE, lat, wr, rd, ma, mw, e, rdat, orv, arv);
        checks++;
        if (lat != 3 || wr !== 1'b0 || rd !== 1'b0 || e !== 1'b1 || rdat !== 8'd0) begin
            errors++; $display("FAIL range_16_wr got lat=%0d wr=%b rd=%b err=%b rdata=%h expected 3 0 0 1 00", lat, wr, rd, e, rdat);
        end
        xact(1'b0, 1'b0, 5'd0, 8'h00, lat, wr, rd, ma, mw, e, rdat, orv, arv);
        checks++;
        if (lat != 3 || e !== 1'b0 || rdat !== exp_mem[0]) begin
            errors++; $display("FAIL range_0 got lat=%0d err=%b rdata=%h expected 3 0 %h", lat, e, rdat, exp_mem[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic wr, rd, e, orv, arv; logic [4:0] ma; logic [7:0] mw, rdat;
        logic [41:0] outs;
        bit seen;
        drive(1'b0, 1'b1, 1'b0, 5'd5, 8'h00);
        #1;
        checks++;
        if (a_if.ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready got=%b expected=1", a_if.ready);
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        checks++;
        if (mem_r_en !== 1'b1) begin
            errors++; $display("FAIL rstmid_issue got r_en=%b expected=1", mem_r_en);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        outs = {mem_wr_en, mem_r_en, mem_addr, mem_wdata,
                a_if.ready, a_if.resp_valid, a_if.resp_err, a_if.resp_rdata,
                b_if.ready, b_if.resp_valid, b_if.resp_err, b_if.resp_rdata};
        checks++;
        if (outs !== 42'd0) begin
            errors++; $display("FAIL rstmid_outputs got=%h expected=0", outs);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (a_if.resp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rstmid_no_resp got resp_valid=1 expected=0");
        end
        xact(1'b0, 1'b0, 5'd5, 8'h00, lat, wr, rd, ma, mw, e, rdat, orv, arv);
        checks++;
        if (lat != 3 || e !== 1'b0 || rdat !== exp_mem[5]) begin
            errors++; $display("FAIL rstmid_after got lat=%0d err=%b rdata=%h expected 3 0 %h", lat, e, rdat, exp_mem[5]);
        end
    endtask

    task automatic test_wr_then_rd();
        int acc_b_cyc = -1, acc_a_cyc = -1, resp_a_cyc = -1, resp_b_cyc = -1;
        logic [7:0] a_rdata = 'x;
        drive(1'b1, 1'b1, 1'b1, 5'd2, 8'hA5);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (mem_wr_en === 1'b1 && mem_r_en === 1'b1) begin
                errors++; $display("FAIL wr_rd_exclusive cycle=%0d got both=1 expected not both", k);
            end
            if (a_if.resp_valid === 1'b1) begin resp_a_cyc = k; a_rdata = a_if.resp_rdata; end
            if (b_if.resp_valid === 1'b1) resp_b_cyc = k;
            #1;
            if (b_if.valid && b_if.ready) acc_b_cyc = k;
            if (a_if.valid && a_if.ready) acc_a_cyc = k;
            @(posedge clk);
            @(negedge clk);
            if (acc_b_cyc == k) begin
                drive(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
                drive(1'b0, 1'b1, 1'b0, 5'd2, 8'h00);
            end
            if (acc_a_cyc == k) drive(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        end
        exp_mem[2] = 8'hA5;
        checks++;
        if (acc_b_cyc != 0 || acc_a_cyc != 4 || resp_b_cyc != 3 || resp_a_cyc != 7) begin
            errors++;
            $display("FAIL wr_rd_timing got accB=%0d accA=%0d respB=%0d respA=%0d expected 0 4 3 7",
                     acc_b_cyc, acc_a_cyc, resp_b_cyc, resp_a_cyc);
        end
        checks++;
        if (a_rdata !== 8'hA5) begin
            errors++; $display("FAIL wr_rd_data got=%h expected=a5", a_rdata);
        end
    endtask

    task automatic test_random_traffic();
        exp_t q[$];
        exp_t e;
        bit   pend [2];
        bit   p_we [2];
        logic [4:0] p_addr [2];
        logic [7:0] p_wd [2];
        bit   acc [2];
        bit   rv [2];
        bit   exp_rv [2];
        bit   perr [2];
        logic [7:0] prd [2];
        int   n_acc = 0, n_resp = 0;
        pend = '{1'b0, 1'b0};
        for (int k = 0; k < 420; k++) begin
            rv[0] = a_if.resp_valid; rv[1] = b_if.resp_valid;
            perr[0] = a_if.resp_err; perr[1] = b_if.resp_err;
            prd[0] = a_if.resp_rdata; prd[1] = b_if.resp_rdata;
            for (int r = 0; r < 2; r++)
                exp_rv[r] = (q.size() > 0) && (q[0].due == cyc) && (q[0].owner == r[0]);
            for (int r = 0; r < 2; r++) begin
                checks++;
                if (rv[r] !== exp_rv[r]) begin
                    errors++; $display("FAIL rnd_resp_valid req=%0d cycle=%0d got=%b expected=%b", r, cyc, rv[r], exp_rv[r]);
                end else if (exp_rv[r] && (perr[r] !== q[0].err || prd[r] !== q[0].rdata)) begin
                    errors++;
                    $display("FAIL rnd_resp_data req=%0d cycle=%0d got err=%b rdata=%h expected err=%b rdata=%h",
                             r, cyc, perr[r], prd[r], q[0].err, q[0].rdata);
                end
            end
            if (exp_rv[0] || exp_rv[1]) begin void'(q.pop_front()); n_resp++; end
            checks++;
            if (mem_wr_en === 1'b1 && mem_r_en === 1'b1) begin
                errors++; $display("FAIL rnd_exclusive cycle=%0d got both=1 expected not both", cyc);
            end
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && k < 400 && $urandom_range(0, 2) != 0) begin
                    pend[r] = 1'b1;
                    p_we[r] = 1'($urandom_range(0, 1));
                    p_addr[r] = 5'($urandom_range(0, 19));
                    p_wd[r] = 8'($urandom);
                    drive(r[0], 1'b1, p_we[r], p_addr[r], p_wd[r]);
                end
            end
            #1;
            acc[0] = a_if.valid & a_if.ready;
            acc[1] = b_if.valid & b_if.ready;
            checks++;
            if (acc[0] && acc[1]) begin
                errors++; $display("FAIL rnd_double_accept cycle=%0d got=2 expected<=1", cyc);
            end
            for (int r = 0; r < 2; r++) begin
                if (acc[r]) begin
                    e.owner = r[0];
                    e.due   = cyc + 3;
                    if (p_addr[r] >= 16) begin
                        e.err = 1'b1; e.rdata = 8'd0;
                    end else if (p_we[r]) begin
                        e.err = 1'b0; e.rdata = 8'd0; exp_mem[p_addr[r][3:0]] = p_wd[r];
                    end else begin
                        e.err = 1'b0; e.rdata = exp_mem[p_addr[r][3:0]];
                    end
                    q.push_back(e);
                    n_acc++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (acc[r]) begin
                    pend[r] = 1'b0;
                    drive(r[0], 1'b0, 1'b0, 5'd0, 8'h00);
                end
            end
        end
        checks++;
        if (q.size() != 0 || n_resp != n_acc || pend[0] || pend[1]) begin
            errors++;
            $display("FAIL rnd_drain got outstanding=%0d resp=%0d acc=%0d pendA=%0d pendB=%0d expected 0 equal 0 0",
                     q.size(), n_resp, n_acc, pend[0], pend[1]);
        end
        checks++;
        if (n_acc < 40) begin
            errors++; $display("FAIL rnd_activity got accepts=%0d expected>=40", n_acc);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        @(negedge clk);
        test_reset();
        test_tie();
        preload();
        test_write_read();
        test_range();
        test_reset_mid();
        test_wr_then_rd();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
